// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, 8-bit ALU, multi-cycle shift-add
// multiplier with upstream stall, and registered zero/carry flags.
module ex_stage #(
   parameter int DATA_W = 8,
   parameter int REG_AW = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ID_EX_Valid,
   input  logic              ID_EX_RegWrite,
   input  logic [REG_AW-1:0] ID_EX_Reg,
   input  logic [REG_AW-1:0] ID_EX_Rs1,
   input  logic [REG_AW-1:0] ID_EX_Rs2,
   input  logic [DATA_W-1:0] ID_EX_Op1,
   input  logic [DATA_W-1:0] ID_EX_Op2,
   input  logic [3:0]        ID_EX_ALUOp,
   input  logic              EX_WB_RegWrite,
   input  logic [REG_AW-1:0] EX_WB_Reg,
   input  logic [DATA_W-1:0] EX_WB_ALUResult,
   output logic              EX_RegWrite,
   output logic [REG_AW-1:0] EX_Reg,
   output logic [DATA_W-1:0] ALUResult,
   output logic              Stall,
   output logic              Z_flag,
   output logic              C_flag
);

   localparam int CNT_W  = $clog2(DATA_W);
   localparam int PROD_W = 2 * DATA_W;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_AND = 4'd2;
   localparam logic [3:0] OP_OR  = 4'd3;
   localparam logic [3:0] OP_XOR = 4'd4;
   localparam logic [3:0] OP_NOT = 4'd5;
   localparam logic [3:0] OP_SHL = 4'd6;
   localparam logic [3:0] OP_SHR = 4'd7;
   localparam logic [3:0] OP_MOV = 4'd8;
   localparam logic [3:0] OP_MUL = 4'd9;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t              state, next_state;
   logic [CNT_W-1:0]    count;
   logic [DATA_W-1:0]   mul_a, mul_b;
   logic [PROD_W-1:0]   acc;

   logic [DATA_W-1:0]   op_a, op_b;
   logic [DATA_W:0]     sum;
   logic [DATA_W-1:0]   alu_res;
   logic                alu_c;
   logic                alu_legal;
   logic [PROD_W-1:0]   partial;

   logic                mul_start;
   logic                flag_we;
   logic                flag_z_n, flag_c_n;

   // Operand forwarding from the writeback stage.
   always_comb begin
      op_a = (EX_WB_RegWrite && (EX_WB_Reg == ID_EX_Rs1)) ? EX_WB_ALUResult : ID_EX_Op1;
      op_b = (EX_WB_RegWrite && (EX_WB_Reg == ID_EX_Rs2)) ? EX_WB_ALUResult : ID_EX_Op2;
   end

   // Single-cycle ALU; MUL and illegal codes yield zero here.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      alu_res   = '0;
      alu_c     = 1'b0;
      alu_legal = 1'b1;
      sum       = {1'b0, op_a} + {1'b0, op_b};
      case (ID_EX_ALUOp)
         OP_ADD: begin
            alu_res = sum[DATA_W-1:0];
            alu_c   = sum[DATA_W];
         end
         OP_SUB: begin
            alu_res = op_a - op_b;
            alu_c   = (op_a < op_b);
         end
         OP_AND: alu_res = op_a & op_b;
         OP_OR:  alu_res = op_a | op_b;
         OP_XOR: alu_res = op_a ^ op_b;
         OP_NOT: alu_res = ~op_a;
         OP_SHL: begin
            alu_res = {op_a[DATA_W-2:0], 1'b0};
            alu_c   = op_a[DATA_W-1];
         end
         OP_SHR: begin
            alu_res = {1'b0, op_a[DATA_W-1:1]};
            alu_c   = op_a[0];
         end
         OP_MOV: alu_res = op_b;
         OP_MUL: alu_res = '0;
         default: alu_legal = 1'b0;
      endcase
   end

   // One shift-add step: add the multiplicand shifted to the current bit position.
   always_comb begin
      partial = mul_b[count] ? ({{DATA_W{1'b0}}, mul_a} << count) : '0;
   end

   // Next-state and output decode for the multiply sequencer.
   always_comb begin
      next_state  = state;
      Stall       = 1'b0;
      EX_RegWrite = 1'b0;
      EX_Reg      = ID_EX_Reg;
      ALUResult   = '0;
      mul_start   = 1'b0;
      flag_we     = 1'b0;
      flag_z_n    = 1'b0;
      flag_c_n    = 1'b0;
      if (!rst) begin
         case (state)
            IDLE: begin
               if (ID_EX_Valid && (ID_EX_ALUOp == OP_MUL)) begin
                  Stall      = 1'b1;
                  mul_start  = 1'b1;
                  next_state = BUSY;
               end else if (alu_legal && (ID_EX_ALUOp != OP_MUL)) begin
                  ALUResult   = alu_res;
                  EX_RegWrite = ID_EX_Valid && ID_EX_RegWrite;
                  flag_we     = ID_EX_Valid;
                  flag_z_n    = (alu_res == '0);
                  flag_c_n    = alu_c;
               end
            end
            BUSY: begin
               Stall = 1'b1;
               if (count == CNT_W'(DATA_W - 1)) next_state = DONE;
            end
            DONE: begin
               ALUResult   = acc[DATA_W-1:0];
               EX_RegWrite = ID_EX_RegWrite;
               flag_we     = 1'b1;
               flag_z_n    = (acc[DATA_W-1:0] == '0);
               flag_c_n    = (acc[PROD_W-1:DATA_W] != '0);
               next_state  = IDLE;
            end
            default: next_state = IDLE;
         endcase
      end
   end

   // State, multiplier datapath and flag registers.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
      if (rst) begin
         state  <= IDLE;
         count  <= '0;
         mul_a  <= '0;
         mul_b  <= '0;
         acc    <= '0;
         Z_flag <= 1'b0;
         C_flag <= 1'b0;
      end else begin
         state <= next_state;
         if (mul_start) begin
            mul_a <= op_a;
            mul_b <= op_b;
            acc   <= '0;
            count <= '0;
         end else if (state == BUSY) begin
            acc   <= acc + partial;
            count <= count + 1'b1;
         end
         if (flag_we) begin
            Z_flag <= flag_z_n;
            C_flag <= flag_c_n;
         end
      end
   end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed cases plus randomized ops
// compared against an arithmetic reference model.
module tb_ex_stage;

   logic       clk = 1'b0;
   logic       rst;
   logic       ID_EX_Valid, ID_EX_RegWrite;
   logic [2:0] ID_EX_Reg, ID_EX_Rs1, ID_EX_Rs2;
   logic [7:0] ID_EX_Op1, ID_EX_Op2;
   logic [3:0] ID_EX_ALUOp;
   logic       EX_WB_RegWrite;
   logic [2:0] EX_WB_Reg;
   logic [7:0] EX_WB_ALUResult;
   logic       EX_RegWrite;
   logic [2:0] EX_Reg;
   logic [7:0] ALUResult;
   logic       Stall, Z_flag, C_flag;

   int checks = 0;
   int errors = 0;
   int m_z = 0;
   int m_c = 0;

   ex_stage #(.DATA_W(8), .REG_AW(3)) dut (
      .clk(clk), .rst(rst),
      .ID_EX_Valid(ID_EX_Valid), .ID_EX_RegWrite(ID_EX_RegWrite),
      .ID_EX_Reg(ID_EX_Reg), .ID_EX_Rs1(ID_EX_Rs1), .ID_EX_Rs2(ID_EX_Rs2),
      .ID_EX_Op1(ID_EX_Op1), .ID_EX_Op2(ID_EX_Op2), .ID_EX_ALUOp(ID_EX_ALUOp),
      .EX_WB_RegWrite(EX_WB_RegWrite), .EX_WB_Reg(EX_WB_Reg),
      .EX_WB_ALUResult(EX_WB_ALUResult),
      .EX_RegWrite(EX_RegWrite), .EX_Reg(EX_Reg), .ALUResult(ALUResult),
      .Stall(Stall), .Z_flag(Z_flag), .C_flag(C_flag)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference ALU from the operation table, in plain integer arithmetic.
   function automatic void ref_alu(input int op, input int a, input int b,
                                   output int res, output int c, output bit legal);
      legal = 1'b1;
      c     = 0;
      res   = 0;
      case (op)
         0: begin res = a + b; c = (res > 255); end
         1: begin res = a - b; c = (a < b); end
         2: res = a & b;
         3: res = a | b;
         4: res = a ^ b;
         5: res = ~a;
         6: begin res = a * 2; c = (a >= 128); end
         7: begin res = a / 2; c = a % 2; end
         8: res = b;
         9: begin res = a * b; c = ((a * b) > 255); end
         default: legal = 1'b0;
      endcase
      res = res & 255;
   endfunction

   function automatic int fwd(input int rs, input int op, input int wb_we,
                              input int wb_reg, input int wb_data);
      return (wb_we != 0 && wb_reg == rs) ? wb_data : op;
   endfunction

   task automatic set_inputs(input int valid, input int rw, input int rd, input int rs1,
                             input int rs2, input int op1, input int op2, input int op,
                             input int wb_we, input int wb_reg, input int wb_data);
      ID_EX_Valid     = valid[0];
      ID_EX_RegWrite  = rw[0];
      ID_EX_Reg       = rd[2:0];
      ID_EX_Rs1       = rs1[2:0];
      ID_EX_Rs2       = rs2[2:0];
      ID_EX_Op1       = op1[7:0];
      ID_EX_Op2       = op2[7:0];
      ID_EX_ALUOp     = op[3:0];
      EX_WB_RegWrite  = wb_we[0];
      EX_WB_Reg       = wb_reg[2:0];
      EX_WB_ALUResult = wb_data[7:0];
   endtask

   // Single-cycle operation (also used for illegal codes and invalid slots).
   task automatic do_single(input string tag, input int valid, input int rw, input int rd,
                            input int rs1, input int rs2, input int op1, input int op2,
                            input int op, input int wb_we, input int wb_reg, input int wb_data);
      int a, b, res, c;
      bit legal;
      @(negedge clk);
      set_inputs(valid, rw, rd, rs1, rs2, op1, op2, op, wb_we, wb_reg, wb_data);
      a = fwd(rs1, op1, wb_we, wb_reg, wb_data);
      b = fwd(rs2, op2, wb_we, wb_reg, wb_data);
      ref_alu(op, a, b, res, c, legal);
      #1;
      check({tag, ".stall"}, Stall, 0);
      check({tag, ".regwrite"}, EX_RegWrite, (valid != 0 && rw != 0 && legal) ? 1 : 0);
      check({tag, ".reg"}, EX_Reg, rd);
      if (valid != 0) check({tag, ".result"}, ALUResult, legal ? res : 0);
      @(posedge clk);
      #1;
      if (valid != 0 && legal) begin
         m_z = (res == 0);
         m_c = c;
      end
      check({tag, ".z"}, Z_flag, m_z);
      check({tag, ".c"}, C_flag, m_c);
   endtask

   // Full 10-cycle multiply; EX_WB is scrambled after capture to prove operands were latched.
   task automatic do_mul(input string tag, input int rw, input int rd, input int rs1,
                         input int rs2, input int op1, input int op2,
                         input int wb_we, input int wb_reg, input int wb_data);
      int a, b, prod, stall_ok, rw_ok, res_ok;
      @(negedge clk);
      set_inputs(1, rw, rd, rs1, rs2, op1, op2, 9, wb_we, wb_reg, wb_data);
      a    = fwd(rs1, op1, wb_we, wb_reg, wb_data);
      b    = fwd(rs2, op2, wb_we, wb_reg, wb_data);
      prod = a * b;
      stall_ok = 1;
      rw_ok    = 1;
      res_ok   = 1;
      for (int cyc = 1; cyc <= 9; cyc++) begin
         #1;
         if (Stall !== 1'b1) stall_ok = 0;
         if (EX_RegWrite !== 1'b0) rw_ok = 0;
         if (cyc > 1 && ALUResult !== 8'h00) res_ok = 0;
         @(posedge clk);
         #1;
         if (cyc == 1) begin
            EX_WB_RegWrite  = $urandom_range(0, 1);
            EX_WB_ALUResult = 8'($urandom);
         end
         @(negedge clk);
      end
      check({tag, ".stall9"}, stall_ok, 1);
      check({tag, ".norw9"}, rw_ok, 1);
      check({tag, ".busyres"}, res_ok, 1);
      #1;
      check({tag, ".done_stall"}, Stall, 0);
      check({tag, ".done_rw"}, EX_RegWrite, rw);
      check({tag, ".done_reg"}, EX_Reg, rd);
      check({tag, ".done_res"}, ALUResult, prod & 255);
      @(posedge clk);
      #1;
      m_z = ((prod & 255) == 0);
      m_c = (prod > 255);
      check({tag, ".z"}, Z_flag, m_z);
      check({tag, ".c"}, C_flag, m_c);
   endtask

   initial begin
      int rw_seen;
      set_inputs(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      rst = 1'b1;
      @(negedge clk);
      check("reset.stall", Stall, 0);
      check("reset.regwrite", EX_RegWrite, 0);
      repeat (2) @(posedge clk);
      #1;
      check("reset.z", Z_flag, 0);
      check("reset.c", C_flag, 0);
      @(negedge clk);
      rst = 1'b0;

      // ADD with carry-out
      do_single("add", 1, 1, 3, 1, 2, 8'hF0, 8'h20, 0, 0, 0, 0);
      // SUB of equal values, A forwarded
      do_single("sub_fwd", 1, 1, 4, 2, 5, 8'h00, 8'h55, 1, 1, 2, 8'h55);
      // MUL 0x12 * 0x0B
      do_mul("mul", 1, 5, 1, 2, 8'h12, 8'h0B, 0, 0, 0);
      // MUL overflow, A forwarded then EX_WB scrambled
      do_mul("mul_ovf", 1, 6, 3, 4, 8'h07, 8'h10, 1, 3, 8'h20);
      // Illegal op: flags keep the MUL overflow values
      do_single("illegal", 1, 1, 2, 0, 1, 8'h33, 8'h44, 12, 0, 0, 0);
      // Invalid ADD: no write, flags unchanged
      do_single("invalid", 0, 1, 2, 0, 1, 8'h00, 8'h00, 0, 0, 0, 0);
      // SHL/SHR edge bits
      do_single("shl", 1, 1, 1, 0, 1, 8'h81, 8'h00, 6, 0, 0, 0);
      do_single("shr", 1, 1, 1, 0, 1, 8'h01, 8'h00, 7, 0, 0, 0);

      // Back-to-back multiplies
      do_mul("mul_b2b1", 1, 1, 0, 1, 8'hFF, 8'hFF, 0, 0, 0);
      do_mul("mul_b2b2", 0, 2, 0, 1, 8'h03, 8'h05, 0, 0, 0);

      // Make flags nonzero, then reset during BUSY cycle 4
      do_mul("pre_rst", 1, 1, 0, 1, 8'h20, 8'h10, 0, 0, 0);
      @(negedge clk);
      set_inputs(1, 1, 7, 0, 1, 8'h0F, 8'h0F, 9, 0, 0, 0);
      repeat (4) @(negedge clk);
      rst = 1'b1;
      ID_EX_Valid = 1'b0;
      #1;
      check("rst_mid.stall_in_rst", Stall, 0);
      check("rst_mid.rw_in_rst", EX_RegWrite, 0);
      @(negedge clk);
      rst = 1'b0;
      m_z = 0;
      m_c = 0;
      #1;
      check("rst_mid.stall", Stall, 0);
      check("rst_mid.regwrite", EX_RegWrite, 0);
      check("rst_mid.z", Z_flag, 0);
      check("rst_mid.c", C_flag, 0);
      rw_seen = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         #1;
         if (EX_RegWrite !== 1'b0 || Stall !== 1'b0) rw_seen = 1;
      end
      check("rst_mid.no_write", rw_seen, 0);

      // Randomized mix, including forwarding hits and illegal codes
      for (int i = 0; i < 60; i++) begin
         int op, valid, rw, rd, rs1, rs2, op1, op2, wb_we, wb_reg, wb_data;
         op      = $urandom_range(0, 15);
         valid   = ($urandom_range(0, 7) != 0);
         rw      = $urandom_range(0, 1);
         rd      = $urandom_range(0, 7);
         rs1     = $urandom_range(0, 7);
         rs2     = $urandom_range(0, 7);
         op1     = $urandom_range(0, 255);
         op2     = $urandom_range(0, 255);
         wb_we   = $urandom_range(0, 1);
         wb_reg  = $urandom_range(0, 7);
         wb_data = $urandom_range(0, 255);
         if (op == 9 && valid != 0)
            do_mul("rnd_mul", rw, rd, rs1, rs2, op1, op2, wb_we, wb_reg, wb_data);
         else
            do_single("rnd", valid, rw, rd, rs1, rs2, op1, op2, op, wb_we, wb_reg, wb_data);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 4-stage pipeline. Sits between the ID/EX register and ex_wb.
- Forwards EX/WB results into the operands and computes the 8-bit ALU result.
- Runs a multi-cycle shift-add multiply, stalling upstream while it is busy.
- Drives ex_wb inputs (RegWrite, Reg, ALUResult) combinationally and keeps registered Z/C flags.

Parameters:
DATA_W, 8, operand/result width
REG_AW, 3, register address width (8 registers)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, synchronous, active-high
ID_EX_Valid  input  1  instruction present in ID/EX
ID_EX_RegWrite  input  1  instruction writes a register
ID_EX_Reg  input  REG_AW  destination register
ID_EX_Rs1  input  REG_AW  source register A
ID_EX_Rs2  input  REG_AW  source register B
ID_EX_Op1  input  DATA_W  register-file value of Rs1
ID_EX_Op2  input  DATA_W  register-file value of Rs2
ID_EX_ALUOp  input  4  operation code
EX_WB_RegWrite  input  1  forwarding: writeback valid
EX_WB_Reg  input  REG_AW  forwarding: writeback register
EX_WB_ALUResult  input  DATA_W  forwarding: writeback data
EX_RegWrite  output  1  to ex_wb ID_EX_RegWrite
EX_Reg  output  REG_AW  to ex_wb ID_EX_Reg
ALUResult  output  DATA_W  to ex_wb ALUResult
Stall  output  1  freeze PC, IF/ID and ID/EX
Z_flag  output  1  registered zero flag
C_flag  output  1  registered carry flag

Behaviour:
- Clock/reset:
  - One clock, clk.
  - rst is synchronous and active-high.
  - When rst is sampled high: state=IDLE, count=0, Z_flag=0, C_flag=0, captured operands=0.
  - While rst is high, EX_RegWrite=0 and Stall=0 combinationally.
- Forwarding:
  - A = EX_WB_ALUResult if EX_WB_RegWrite && EX_WB_Reg==ID_EX_Rs1, else ID_EX_Op1.
  - B is forwarded the same way using Rs2/Op2.
- ALUOp encoding:
  - 0 ADD A+B; 1 SUB A-B; 2 AND; 3 OR; 4 XOR; 5 NOT A; 6 SHL A by 1; 7 SHR A by 1 (logical); 8 MOV B; 9 MUL (low 8 bits of A*B).
  - Codes 10-15 are illegal: ALUResult=0, EX_RegWrite=0, flags unchanged.
- Single-cycle ops (state IDLE, ALUOp!=9):
  - Output is combinational, zero added latency.
  - EX_RegWrite = ID_EX_Valid && ID_EX_RegWrite.
  - EX_Reg = ID_EX_Reg.
  - Stall = 0.
- Flags:
  - Updated at the edge where a valid legal result is delivered.
  - Z = (result==0).
  - C per op: ADD carry-out; SUB borrow (A<B); SHL A[7]; SHR A[0]; MUL 1 iff product[15:8]!=0; other ops 0.
- MUL state machine (IDLE, BUSY, DONE):
  - IDLE with ID_EX_Valid && ALUOp==9:
    - Stall=1, EX_RegWrite=0.
    - At the edge: capture forwarded A and B into internal registers, clear the 16-bit accumulator, count=0, go to BUSY.
  - BUSY:
    - Stall=1, EX_RegWrite=0, ALUResult=0.
    - Each edge performs one shift-add step and increments count.
    - After DATA_W steps (count==DATA_W-1 at the edge), go to DONE.
  - DONE:
    - Stall=0.
    - ALUResult = accumulator[7:0].
    - EX_RegWrite = ID_EX_RegWrite.
    - At the edge: update flags, go to IDLE. ID/EX advances on the same edge.
    - DONE never restarts the MUL it is completing.
  - Total MUL occupancy is 10 cycles, with Stall high for 9.
  - Back-to-back MULs each take 10 cycles; the IDLE capture cycle directly follows DONE.
- Operand capture:
  - Captured operands are used throughout, because EX_WB contents change (to bubbles) while stalled.
- Invalid instruction (ID_EX_Valid=0): EX_RegWrite=0, flags unchanged, no MUL start.
- Reset mid-MUL: on the next edge return to IDLE and abandon the product. No write is issued.

Test Plan:
- ADD: Op1=0xF0, Op2=0x20, Reg=3, RegWrite=1 -> same cycle ALUResult=0x10, EX_RegWrite=1, EX_Reg=3; after edge C_flag=1, Z_flag=0.
- SUB equal with forwarding: Rs1=2, Op1=0x00, EX_WB_RegWrite=1, EX_WB_Reg=2, EX_WB_ALUResult=0x55, Op2=0x55 -> ALUResult=0x00; after edge Z_flag=1, C_flag=0.
- MUL: A=0x12, B=0x0B -> Stall=1 for 9 cycles with EX_RegWrite=0; cycle 10 ALUResult=0xC6, EX_RegWrite=1, Stall=0; after edge C_flag=0.
- MUL overflow with forwarding: A=0x20 forwarded from EX_WB, EX_WB set to bubble after the first cycle, B=0x10 -> result 0x00, Z_flag=1, C_flag=1 (product 0x0200).
- Reset mid-MUL: assert rst at BUSY cycle 4 for one cycle with ID_EX_Valid=0 afterwards -> next cycle Stall=0, EX_RegWrite=0, Z_flag=0, C_flag=0, no write issued.
- Illegal op 12 with Valid=1, RegWrite=1 -> ALUResult=0, EX_RegWrite=0, flags unchanged; Valid=0 with ADD -> EX_RegWrite=0.
